// File: rtl/rr_bus_scheduler_if.sv
// Requester/resource handshake bundle for the round-robin bus scheduler.
// master: scheduler side. slave: requesters plus the shared resource.
interface rr_bus_scheduler_if #(
    parameter int N     = 4,
    parameter int W_CNT = 8
);
    localparam int SEL_W = $clog2(N);

    logic [N-1:0]     req;
    logic [N-1:0]     ack;
    logic             err;
    logic [SEL_W-1:0] sel;
    logic             sel_valid;
    logic             res_req;
    logic             res_ack;
    logic             busy;
    logic [W_CNT-1:0] grant_total;
    logic [W_CNT-1:0] timeout_total;

    modport master (
        input  req, res_ack,
        output ack, err, sel, sel_valid, res_req, busy, grant_total, timeout_total
    );

    modport slave (
        output req, res_ack,
        input  ack, err, sel, sel_valid, res_req, busy, grant_total, timeout_total
    );
endinterface

// File: rtl/rr_bus_scheduler.sv
// Round-robin scheduler sharing one four-phase resource between N
// four-phase requesters, with completion watchdog and grant/abort counters.

// One synchronizer lane: SYNC-deep flop chain for an asynchronous level.
module rr_sync_lane #(
    parameter int SYNC = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [SYNC-1:0] sync_pipe;

    // shift the raw level through the chain; the last stage is the only one used
    always_ff @(posedge clk) begin
        if (reset) sync_pipe <= '0;
        else       sync_pipe <= {sync_pipe[SYNC-2:0], d};
    end

    assign q = sync_pipe[SYNC-1];
endmodule

module rr_bus_scheduler #(
    parameter int N       = 4,
    parameter int SYNC    = 2,
    parameter int TIMEOUT = 255,
    parameter int W_CNT   = 8
) (
    input logic               clk,
    input logic               reset,
    rr_bus_scheduler_if.master bus
);
    localparam int SEL_W = $clog2(N);
    // watchdog only ever needs to reach TIMEOUT-1
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    typedef struct packed {
        state_t           state;
        logic [SEL_W-1:0] sel;
        logic [SEL_W-1:0] last;
        logic [N-1:0]     ack;
        logic             err;
        logic             res_req;
        logic [WD_W-1:0]  wd;
        logic [W_CNT-1:0] grants;
        logic [W_CNT-1:0] tmos;
    } regs_t;

    // last = N-1 so user 0 has first priority out of reset
    localparam regs_t R_RST = '{
        state: IDLE, sel: '0, last: SEL_LAST, ack: '0, err: 1'b0,
        res_req: 1'b0, wd: '0, grants: '0, tmos: '0
    };

    logic [N-1:0]     req_raw;
    logic [N-1:0]     req_s;
    logic             res_ack_s;
    logic             found;
    logic [SEL_W-1:0] win;
    logic [SEL_W-1:0] cand;
    regs_t            r_q, r_d;

    assign req_raw = bus.req;

    rr_sync_lane #(.SYNC(SYNC)) u_req_sync [N-1:0] (
        .clk   (clk),
        .reset (reset),
        .d     (req_raw),
        .q     (req_s)
    );

    rr_sync_lane #(.SYNC(SYNC)) u_ack_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.res_ack),
        .q     (res_ack_s)
    );

    // round-robin pick: first synchronized request after last, with wrap
    always_comb begin
        found = 1'b0;
        win   = r_q.last;
        cand  = r_q.last;
        for (int k = 0; k < N; k++) begin
            cand = (cand == SEL_LAST) ? '0 : cand + SEL_W'(1);
            if (!found && req_s[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // state and datapath registers; reset aborts any transaction in flight
    always_ff @(posedge clk) begin
        if (reset) r_q <= R_RST;
        else       r_q <= r_d;
    end

    // next-state: grant, wait for completion or watchdog, wait for release
    always_comb begin
        r_d = r_q;
        case (r_q.state)
            IDLE: begin
                // a completion level still high from an earlier abort blocks new grants
                if (found && !res_ack_s) begin
                    r_d.state   = ISSUE;
                    r_d.sel     = win;
                    r_d.res_req = 1'b1;
                    r_d.wd      = '0;
                end
            end
            ISSUE: begin
                if (res_ack_s) begin
                    r_d.state   = RESP;
                    r_d.res_req = 1'b0;
                    r_d.ack     = {{(N-1){1'b0}}, 1'b1} << r_q.sel;
                    r_d.err     = 1'b0;
                    r_d.grants  = r_q.grants + W_CNT'(1);
                end else if (TIMEOUT != 0 && r_q.wd == WD_LAST) begin
                    r_d.state   = RESP;
                    r_d.res_req = 1'b0;
                    r_d.ack     = {{(N-1){1'b0}}, 1'b1} << r_q.sel;
                    r_d.err     = 1'b1;
                    if (r_q.tmos != '1) r_d.tmos = r_q.tmos + W_CNT'(1);
                end else begin
                    r_d.wd = r_q.wd + WD_W'(1);
                end
            end
            RESP: begin
                // sel holds through the return to idle; only sel_valid drops
                if (!req_s[r_q.sel] && !res_ack_s) begin
                    r_d.state = IDLE;
                    r_d.ack   = '0;
                    r_d.err   = 1'b0;
                    r_d.last  = r_q.sel;
                end
            end
            default: r_d.state = IDLE;
        endcase
    end

    assign bus.ack           = r_q.ack;
    assign bus.err           = r_q.err;
    assign bus.sel           = r_q.sel;
    assign bus.sel_valid     = (r_q.state == ISSUE) || (r_q.state == RESP);
    assign bus.res_req       = r_q.res_req;
    assign bus.busy          = (r_q.state != IDLE);
    assign bus.grant_total   = r_q.grants;
    assign bus.timeout_total = r_q.tmos;
endmodule

// File: tb/tb_rr_bus_scheduler.sv
// Scoreboard bench for rr_bus_scheduler: expected grants are queued as
// requests are raised and popped when an ack rises.
module tb_rr_bus_scheduler;
    localparam int N       = 4;
    localparam int SYNC    = 2;
    localparam int TIMEOUT = 10;
    localparam int W_CNT   = 2;
    localparam int LAT     = SYNC + 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    rr_bus_scheduler_if #(.N(N), .W_CNT(W_CNT)) bus ();

    rr_bus_scheduler #(.N(N), .SYNC(SYNC), .TIMEOUT(TIMEOUT), .W_CNT(W_CNT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [1:0] idx;
        logic       err;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int idx, input logic e);
        sb_q.push_back(exp_t'{idx: 2'(idx), err: e});
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic probe(input int s);
        case (s)
            0:       return bus.res_req;
            1:       return |bus.ack;
            default: return bus.busy;
        endcase
    endfunction

    // count edges until the selected output reaches lvl; bounded
    task automatic wait_for(input int s, input logic lvl, input string tag, output int n);
        n = 0;
        while (probe(s) !== lvl && n < 40) begin
            tick();
            n++;
        end
        if (probe(s) !== lvl) chk({tag, "_timeout"}, 32'(probe(s)), 32'(lvl));
    endtask

    // scoreboard pop on ack rise, and sel stability while sel_valid
    logic [N-1:0] ack_prev = '0;
    logic         sv_prev  = 1'b0;
    logic [1:0]   sel_prev = '0;

    always @(negedge clk) begin
        if (bus.ack != '0 && ack_prev == '0) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_grant", 32'(bus.ack), 32'(0));
            end else begin
                chk("sb_sel", 32'(bus.sel), 32'(sb_q[0].idx));
                chk("sb_ack", 32'(bus.ack), 32'(1) << sb_q[0].idx);
                chk("sb_err", 32'(bus.err), 32'(sb_q[0].err));
                void'(sb_q.pop_front());
            end
        end
        if (bus.sel_valid && sv_prev) chk("sel_stable", 32'(bus.sel), 32'(sel_prev));
        ack_prev <= bus.ack;
        sv_prev  <= bus.sel_valid;
        sel_prev <= bus.sel;
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ack"},       32'(bus.ack), 0);
        chk({tag, "_err"},       32'(bus.err), 0);
        chk({tag, "_sel"},       32'(bus.sel), 0);
        chk({tag, "_sel_valid"}, 32'(bus.sel_valid), 0);
        chk({tag, "_res_req"},   32'(bus.res_req), 0);
        chk({tag, "_busy"},      32'(bus.busy), 0);
        chk({tag, "_grants"},    32'(bus.grant_total), 0);
        chk({tag, "_tmos"},      32'(bus.timeout_total), 0);
    endtask

    // resource side of one completed grant, requester releases afterwards
    task automatic serve(input int who, input string tag);
        int n;
        wait_for(0, 1'b1, {tag, "_res_req"}, n);
        tick(2);
        bus.res_ack = 1'b1;
        wait_for(1, 1'b1, {tag, "_ack"}, n);
        bus.req[who] = 1'b0;
        bus.res_ack  = 1'b0;
        wait_for(2, 1'b0, {tag, "_idle"}, n);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench stuck");
    end

    initial begin
        int n;
        int g;
        reset       = 1'b1;
        bus.req     = '0;
        bus.res_ack = 1'b0;
        tick(3);
        chk_reset_state("rst");
        reset = 1'b0;
        tick();

        // single user 2, resource acks a few cycles after res_req
        bus.req = 4'b0100;
        push(2, 1'b0);
        wait_for(0, 1'b1, "single_res_req", n);
        chk("req_to_res_req_lat", 32'(n), 32'(LAT));
        chk("single_sel", 32'(bus.sel), 2);
        chk("single_sel_valid", 32'(bus.sel_valid), 1);
        chk("single_busy", 32'(bus.busy), 1);
        tick(4);
        bus.res_ack = 1'b1;
        wait_for(1, 1'b1, "single_ack", n);
        chk("res_ack_to_ack_lat", 32'(n), 32'(LAT));
        chk("single_res_req_low", 32'(bus.res_req), 0);
        bus.req     = '0;
        bus.res_ack = 1'b0;
        wait_for(1, 1'b0, "single_ack_fall", n);
        chk("release_to_ack_fall_lat", 32'(n), 32'(LAT));
        chk("single_idle", 32'(bus.busy), 0);
        chk("single_sel_valid_drop", 32'(bus.sel_valid), 0);
        chk("single_sel_hold", 32'(bus.sel), 2);
        chk("single_grants", 32'(bus.grant_total), 1);
        chk("single_tmos", 32'(bus.timeout_total), 0);

        // fairness from reset: all four requesting, order 0,1,2,3,0,...
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            g = k % 4;
            push(g, 1'b0);
            wait_for(0, 1'b1, "fair_res_req", n);
            tick(2);
            bus.res_ack = 1'b1;
            wait_for(1, 1'b1, "fair_ack", n);
            if (k == 7) bus.req = '0;
            else        bus.req[g] = 1'b0;
            bus.res_ack = 1'b0;
            wait_for(2, 1'b0, "fair_idle", n);
            if (k != 7) bus.req[g] = 1'b1;
            if (k == 4) chk("grant_wrap_5", 32'(bus.grant_total), 1);
        end
        chk("grant_wrap_8", 32'(bus.grant_total), 0);

        // watchdog: resource never answers
        bus.req = 4'b0001;
        push(0, 1'b1);
        wait_for(0, 1'b1, "wd_res_req", n);
        wait_for(0, 1'b0, "wd_abort", n);
        chk("wd_issue_edges", 32'(n), 32'(TIMEOUT));
        chk("wd_err", 32'(bus.err), 1);
        chk("wd_ack", 32'(bus.ack), 32'h1);
        chk("wd_tmos", 32'(bus.timeout_total), 1);
        chk("wd_grants", 32'(bus.grant_total), 0);
        bus.req = '0;
        wait_for(2, 1'b0, "wd_idle", n);
        chk("wd_idle_busy", 32'(bus.busy), 0);

        // stale completion level blocks a new grant until it falls
        bus.res_ack = 1'b1;
        tick(3);
        bus.req = 4'b0010;
        tick(8);
        chk("stale_no_res_req", 32'(bus.res_req), 0);
        chk("stale_no_busy", 32'(bus.busy), 0);
        push(1, 1'b0);
        bus.res_ack = 1'b0;
        wait_for(0, 1'b1, "stale_res_req", n);
        chk("stale_release_lat", 32'(n), 32'(LAT));
        serve(1, "stale");
        chk("stale_grants", 32'(bus.grant_total), 1);

        // reset with res_req high, then user 0 must win against user 3
        bus.req = 4'b1000;
        wait_for(0, 1'b1, "rst_mid_res_req", n);
        tick(2);
        reset = 1'b1;
        tick();
        chk_reset_state("rst_mid");
        bus.req = 4'b1001;
        tick();
        reset = 1'b0;
        push(0, 1'b0);
        push(3, 1'b0);
        wait_for(0, 1'b1, "rst_first_res_req", n);
        chk("rst_first_winner", 32'(bus.sel), 0);
        serve(0, "rst_u0");
        serve(3, "rst_u3");
        chk("rst_grants", 32'(bus.grant_total), 2);

        // five aborts: timeout_total saturates at 3
        for (int k = 0; k < 5; k++) begin
            bus.req = 4'b0100;
            push(2, 1'b1);
            wait_for(1, 1'b1, "abort_ack", n);
            bus.req = '0;
            wait_for(2, 1'b0, "abort_idle", n);
            chk("tmo_sat", 32'(bus.timeout_total), (k + 1 > 3) ? 32'd3 : 32'(k + 1));
        end
        chk("abort_grants", 32'(bus.grant_total), 2);

        tick(3);
        chk("sb_drain", 32'(sb_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
